// File: rtl/hazard_stall_unit.sv
// Stall, bubble, flush and freeze control for the 5-stage pipeline, with a data-memory watchdog.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic             IF_ID_Branch,
  input  logic             Branch_Taken,
  input  logic [4:0]       ID_EX_Rt,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [4:0]       EX_MEM_Rd,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_ID_Flush,
  output logic             MEM_WB_Bubble,
  output logic             mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam int unsigned CntW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {StRun, StMwait, StErr} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;

  logic mem_busy;
  logic match_ex_rt, match_ex_rd, match_mem_rd;
  logic hazard;

  assign mem_busy = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~dmem_ready;

  assign match_ex_rt  = (ID_EX_Rt != 5'd0) &
                        ((ID_EX_Rt == IF_ID_Rs) | (IF_ID_UsesRt & (ID_EX_Rt == IF_ID_Rt)));
  assign match_ex_rd  = (ID_EX_Rd != 5'd0) &
                        ((ID_EX_Rd == IF_ID_Rs) | (IF_ID_UsesRt & (ID_EX_Rd == IF_ID_Rt)));
  assign match_mem_rd = (EX_MEM_Rd != 5'd0) &
                        ((EX_MEM_Rd == IF_ID_Rs) | (IF_ID_UsesRt & (EX_MEM_Rd == IF_ID_Rt)));

  // Branches compare in ID, so even ALU results in EX and loads in MEM cannot be forwarded.
  assign hazard = (ID_EX_MemRead & match_ex_rt) |
                  (IF_ID_Branch & ID_EX_RegWrite & match_ex_rd) |
                  (IF_ID_Branch & EX_MEM_MemRead & match_mem_rd);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    wait_cnt_inc = wait_cnt_q + CntW'(1);
    unique case (state_q)
      StRun, StMwait: begin
        if (mem_busy) begin
          wait_cnt_d = wait_cnt_inc;
          state_d    = (wait_cnt_inc >= TimeoutVal) ? StErr : StMwait;
        end else begin
          wait_cnt_d = '0;
          state_d    = StRun;
        end
      end
      StErr:   state_d = StErr;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    ID_EX_Bubble  = 1'b0;
    IF_ID_Flush   = 1'b0;
    MEM_WB_Bubble = 1'b0;
    mem_timeout   = 1'b0;
    if (!rst) begin
      if (state_q == StErr) begin
        {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write} = 4'b0000;
        MEM_WB_Bubble = 1'b1;
        mem_timeout   = 1'b1;
      end else if (mem_busy) begin
        {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write} = 4'b0000;
        MEM_WB_Bubble = 1'b1;
      end else if (hazard) begin
        // Operands are stale, so a taken branch this cycle is not acted on.
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end else if (Branch_Taken) begin
        IF_ID_Flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = PCWrite ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
    flush_cnt_d = IF_ID_Flush ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`endif

endmodule
